match_ctrl: RTL
===============

Name: match_ctrl

Overview:
Round/match sequencer for the tug-of-war game. It watches the playfield's edge-win indications and arbitrates a simultaneous win. It issues single-cycle count enables to the two external per-player score up-counters, holds the playfield in reset between rounds, and declares the match winner when a score reaches the target. It sits between the playfield logic and the two score counter instances, which are driven by their count-enable input.

Parameters:
WIDTH, 3, score width; must match the external score counters.
WIN_SCORE, 7, score that ends the match (compare uses >=).
HOLD_CYCLES, 4, cycles round_rst stays high between rounds; must be >= 1.

Ports:
CLOCK_50  input  1  system clock.
reset  input  1  synchronous, active-high; reset reset, synchronous, active-high; clock CLOCK_50.
left_win  input  1  level from playfield: light at left end.
right_win  input  1  level from playfield: light at right end.
left_score  input  WIDTH  current value of the left score counter.
right_score  input  WIDTH  current value of the right score counter.
left_inc  output  1  one-cycle count enable to the left score counter.
right_inc  output  1  one-cycle count enable to the right score counter.
round_rst  output  1  playfield reset request.
match_over  output  1  high once the match is decided.
winner  output  1  0 = left, 1 = right; valid while match_over = 1.

Behaviour:
- Moore FSM; all outputs decoded from registered state and flags. States: PLAY, SCORE, CHECK, HOLD, OVER.
- Reset: state = PLAY. left_inc = right_inc = round_rst = match_over = winner = 0. Hold counter = 0.
- Reset has priority over every transition. Asserting reset mid-HOLD or in OVER returns to PLAY on the next edge.
- PLAY: left_win only -> SCORE, side latched = left. right_win only -> SCORE, side latched = right. Neither -> stay in PLAY.
- Both left_win and right_win high: see Optional Feature.
- SCORE (exactly 1 cycle): the inc output for the latched side = 1; the other inc = 0. Next state is CHECK.
- Latency: win sampled at edge k -> inc high during cycle k+1 -> counter updates at edge k+2 -> CHECK during cycle k+2.
- CHECK (1 cycle): latched side's score >= WIN_SCORE -> OVER. Otherwise -> HOLD, hold counter loaded to HOLD_CYCLES-1.
- HOLD: round_rst = 1. Win inputs are ignored. Counter decrements each cycle; at 0 -> PLAY. round_rst is high for exactly HOLD_CYCLES cycles.
- OVER: match_over = 1, round_rst = 1, winner = latched side. Win inputs are ignored. Exit only via reset.
- left_inc and right_inc are never high together, and never high outside SCORE.
- No arithmetic wrap is possible: the controller stops issuing increments once OVER is reached.
- A score already >= WIN_SCORE at reset is not checked until the next CHECK state.

Optional Feature:
MATCH_TIE_REPLAY_EN.
- Defined: both wins high in PLAY -> HOLD directly. No increment is issued and the round is replayed.
- Undefined: both wins high -> left has fixed priority and the FSM goes to SCORE with side = left.

Decomposition:
- Package match_pkg holds: state_t enum (PLAY, SCORE, CHECK, HOLD, OVER), side_t (LEFT = 0, RIGHT = 1), and default constants for WIN_SCORE and HOLD_CYCLES.
- The hold timer is inline; a separate sub-module is not warranted.
- Score counters stay external as existing up-counter instances, one per player, with reset tied to system reset.
- Bench instantiates match_ctrl plus two WIDTH-bit up-counters wired inc -> enable, score -> score input.

Test Plan:
All scenarios use WIN_SCORE = 3, HOLD_CYCLES = 4.
- Reset: hold reset 2 cycles -> all outputs 0, state PLAY, both scores 0.
- Single left point: left_win pulsed 1 cycle -> left_inc high exactly 1 cycle, one cycle later; left_score = 1; round_rst high 4 cycles; back in PLAY; right_inc never high.
- Win during HOLD: right_win held high through HOLD -> no right_inc until back in PLAY; then exactly one right_inc; right_score = 1.
- Match end: three right points -> right_score = 3, match_over = 1, winner = 1, round_rst stays 1. A further left_win produces no inc. Reset -> all outputs 0.
- Tie, MATCH_TIE_REPLAY_EN defined: both wins high 1 cycle -> no inc, round_rst 4 cycles, scores unchanged.
- Tie, macro undefined: both wins high 1 cycle -> left_inc 1 cycle, left_score increments.

Source files
------------

// File: rtl/match_pkg.sv
// Shared types and default constants for the tug-of-war match sequencer.
// Optional build macro: MATCH_TIE_REPLAY_EN (replay a round on a simultaneous win).
package match_pkg;

  typedef enum logic [2:0] {
    PLAY  = 3'd0,
    SCORE = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    OVER  = 3'd4
  } state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } side_t;

  localparam int DEF_WIDTH       = 3;
  localparam int DEF_WIN_SCORE   = 7;
  localparam int DEF_HOLD_CYCLES = 4;

endpackage

// File: rtl/match_ctrl.sv
// Round/match sequencer: scores edge wins, holds the playfield between rounds, declares the winner.
// Optional build macro: MATCH_TIE_REPLAY_EN (simultaneous win replays the round instead of left priority).
module match_ctrl
  import match_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             left_win,
  input  logic             right_win,
  input  logic [WIDTH-1:0] left_score,
  input  logic [WIDTH-1:0] right_score,
  output logic             left_inc,
  output logic             right_inc,
  output logic             round_rst,
  output logic             match_over,
  output logic             winner
);

  localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [31:0]     WIN_U     = 32'(WIN_SCORE);

  state_t          r_state, w_state_nxt;
  side_t           r_side,  w_side_nxt;
  logic [HW-1:0]   r_hold,  w_hold_nxt;
  logic [WIDTH-1:0] w_side_score;
  logic            w_reached;

  // In CHECK the counter has already absorbed the increment issued in SCORE.
  assign w_side_score = (r_side == RIGHT) ? right_score : left_score;
  assign w_reached    = (32'(w_side_score) >= WIN_U);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= PLAY;
      r_side  <= LEFT;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_side  <= w_side_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_side_nxt  = r_side;
    w_hold_nxt  = r_hold;
    case (r_state)
      PLAY: begin
        if (left_win && right_win) begin
`ifdef MATCH_TIE_REPLAY_EN
          w_state_nxt = HOLD;
          w_hold_nxt  = HOLD_LOAD;
`else
          w_state_nxt = SCORE;
          w_side_nxt  = LEFT;
`endif
        end else if (left_win) begin
          w_state_nxt = SCORE;
          w_side_nxt  = LEFT;
        end else if (right_win) begin
          w_state_nxt = SCORE;
          w_side_nxt  = RIGHT;
        end
      end
      SCORE: w_state_nxt = CHECK;
      CHECK: begin
        if (w_reached) begin
          w_state_nxt = OVER;
        end else begin
          w_state_nxt = HOLD;
          w_hold_nxt  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (r_hold == '0) w_state_nxt = PLAY;
        else              w_hold_nxt  = r_hold - HW'(1);
      end
      OVER:    w_state_nxt = OVER;
      default: w_state_nxt = PLAY;
    endcase
  end

  assign left_inc   = (r_state == SCORE) && (r_side == LEFT);
  assign right_inc  = (r_state == SCORE) && (r_side == RIGHT);
  assign round_rst  = (r_state == HOLD) || (r_state == OVER);
  assign match_over = (r_state == OVER);
  assign winner     = (r_state == OVER) && (r_side == RIGHT);

endmodule
